// File: rtl/sb_trig_holdoff.sv
// sb_trig_holdoff: turns a single-bin trigger pulse into a request level held until ACK,
// then applies a 40 MHz-tick holdoff; keeps saturating accepted/lost trigger counts.
module sb_trig_holdoff #(
    parameter int HOLDOFF_WIDTH = 12,
    parameter int COUNT_WIDTH   = 24
) (
    input  logic                     CLK120,
    input  logic                     RESETN,
    input  logic [1:0]               ENABLE40,
    input  logic                     ENABLE,
    input  logic                     TRIG_IN,
    input  logic [HOLDOFF_WIDTH-1:0] HOLDOFF,
    input  logic                     TRIG_ACK,
    input  logic                     COUNT_CLR,
    output logic                     TRIG_OUT,
    output logic                     BUSY,
    output logic [COUNT_WIDTH-1:0]   TRIG_COUNT,
    output logic [COUNT_WIDTH-1:0]   LOST_COUNT
);
    typedef enum logic [1:0] {IDLE, PENDING, HOLD} state_t;

    state_t                   state_q;
    logic                     prev_q, trig_out_q, busy_q;
    logic [HOLDOFF_WIDTH-1:0] hold_q;
    logic [COUNT_WIDTH-1:0]   trig_cnt_q, trig_cnt_d, lost_cnt_q, lost_cnt_d;
    logic                     trig_edge, tick;

    assign trig_edge = TRIG_IN & ~prev_q & ENABLE;
    assign tick      = ENABLE40 == 2'd0;

    // Edges while the registered state is busy are lost, even on the exit cycle.
    always_comb begin
        trig_cnt_d = COUNT_CLR ? '0
                   : (trig_edge && state_q == IDLE && ~&trig_cnt_q) ? trig_cnt_q + COUNT_WIDTH'(1)
                   : trig_cnt_q;
        lost_cnt_d = COUNT_CLR ? '0
                   : (trig_edge && state_q != IDLE && ~&lost_cnt_q) ? lost_cnt_q + COUNT_WIDTH'(1)
                   : lost_cnt_q;
    end

    always_ff @(posedge CLK120 or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= IDLE;
            prev_q     <= 1'b0;
            trig_out_q <= 1'b0;
            busy_q     <= 1'b0;
            hold_q     <= '0;
            trig_cnt_q <= '0;
            lost_cnt_q <= '0;
        end else begin
            prev_q     <= TRIG_IN;
            trig_cnt_q <= trig_cnt_d;
            lost_cnt_q <= lost_cnt_d;
            case (state_q)
                IDLE: if (trig_edge) begin
                    state_q    <= PENDING;
                    trig_out_q <= 1'b1;
                    busy_q     <= 1'b1;
                end
                PENDING: if (TRIG_ACK) begin
                    trig_out_q <= 1'b0;
                    if (HOLDOFF == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= HOLD;
                        hold_q  <= HOLDOFF;
                    end
                end
                HOLD: if (tick) begin
                    hold_q <= hold_q - HOLDOFF_WIDTH'(1);
                    if (hold_q == HOLDOFF_WIDTH'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    trig_out_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign TRIG_OUT   = trig_out_q;
    assign BUSY       = busy_q;
    assign TRIG_COUNT = trig_cnt_q;
    assign LOST_COUNT = lost_cnt_q;
endmodule

// File: tb/tb_sb_trig_holdoff.sv
// tb_sb_trig_holdoff: vector table, directed corner sequences and random traffic
// checked against a transaction-level reference model.
module tb_sb_trig_holdoff;
    localparam int HW  = 12;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0, rstn = 1'b0;
    logic [1:0]    en40 = 2'd0;
    logic          en = 1'b1, trig = 1'b0, ack = 1'b0, clr = 1'b0;
    logic [HW-1:0] hold = '0;
    logic          tout, busy;
    logic [CW-1:0] tc, lc;
    int            errors = 0, checks = 0;

    sb_trig_holdoff #(.HOLDOFF_WIDTH(HW), .COUNT_WIDTH(CW)) dut (
        .CLK120(clk), .RESETN(rstn), .ENABLE40(en40), .ENABLE(en), .TRIG_IN(trig),
        .HOLDOFF(hold), .TRIG_ACK(ack), .COUNT_CLR(clr), .TRIG_OUT(tout), .BUSY(busy),
        .TRIG_COUNT(tc), .LOST_COUNT(lc)
    );

    always #5 clk = ~clk;

    // Model: a request is outstanding until ACK, then busy lasts until len ticks were seen.
    bit m_prev, m_pend;
    int m_len, m_ticks, m_tc, m_lc;

    function automatic void model_reset();
        m_prev = 0; m_pend = 0; m_len = 0; m_ticks = 0; m_tc = 0; m_lc = 0;
    endfunction

    function automatic void model_edge();
        bit e, b;
        e = trig && !m_prev && en;
        b = m_pend || m_len != 0;
        m_prev = trig;
        if (clr) begin
            m_tc = 0; m_lc = 0;
        end else if (e && b) m_lc = (m_lc < MAX) ? m_lc + 1 : MAX;
        else if (e) m_tc = (m_tc < MAX) ? m_tc + 1 : MAX;
        if (!b && e) m_pend = 1;
        else if (m_pend && ack) begin
            m_pend = 0; m_len = int'(hold); m_ticks = 0;
        end else if (m_len != 0 && en40 == 2'd0) begin
            m_ticks++;
            if (m_ticks >= m_len) m_len = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        check({tag, ".trig_out"}, 32'(tout), int'(m_pend));
        check({tag, ".busy"}, 32'(busy), int'(m_pend || m_len != 0));
        check({tag, ".trig_count"}, 32'(tc), m_tc);
        check({tag, ".lost_count"}, 32'(lc), m_lc);
    endtask

    task automatic step(input string tag = "model");
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_model(tag);
        en40 = (en40 == 2'd2) ? 2'd0 : en40 + 2'd1;
    endtask

    task automatic async_reset();
        #2 rstn = 1'b0;
        #1;
        check("rst.trig_out", 32'(tout), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.trig_count", 32'(tc), 0);
        check("rst.lost_count", 32'(lc), 0);
        trig = 0; ack = 0; clr = 0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        logic trig, ack, en, clr;
        int   exp_out, exp_busy, exp_tc, exp_lc;
    } vec_t;

    vec_t vt[13];
    int   n;

    initial begin
        vt[0]  = '{1, 0, 1, 0, 1, 1, 1, 0};
        vt[1]  = '{1, 0, 1, 0, 1, 1, 1, 0};
        vt[2]  = '{1, 0, 1, 0, 1, 1, 1, 0};
        vt[3]  = '{0, 0, 1, 0, 1, 1, 1, 0};
        vt[4]  = '{0, 1, 1, 0, 0, 0, 1, 0};
        vt[5]  = '{1, 0, 0, 0, 0, 0, 1, 0};
        vt[6]  = '{0, 0, 1, 0, 0, 0, 1, 0};
        vt[7]  = '{1, 0, 1, 1, 1, 1, 0, 0};
        vt[8]  = '{0, 0, 1, 0, 1, 1, 0, 0};
        vt[9]  = '{1, 0, 1, 0, 1, 1, 0, 1};
        vt[10] = '{0, 0, 1, 1, 1, 1, 0, 0};
        vt[11] = '{0, 1, 1, 0, 0, 0, 0, 0};
        vt[12] = '{0, 1, 1, 0, 0, 0, 0, 0};

        model_reset();
        repeat (3) @(negedge clk);
        check("reset.trig_out", 32'(tout), 0);
        check("reset.busy", 32'(busy), 0);
        check("reset.trig_count", 32'(tc), 0);
        check("reset.lost_count", 32'(lc), 0);
        rstn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            trig = vt[i].trig; ack = vt[i].ack; en = vt[i].en; clr = vt[i].clr;
            step("vec");
            check($sformatf("vec%0d.trig_out", i), 32'(tout), vt[i].exp_out);
            check($sformatf("vec%0d.busy", i), 32'(busy), vt[i].exp_busy);
            check($sformatf("vec%0d.trig_count", i), 32'(tc), vt[i].exp_tc);
            check($sformatf("vec%0d.lost_count", i), 32'(lc), vt[i].exp_lc);
        end
        trig = 0; ack = 0; en = 1; clr = 0;

        clr = 1; step(); clr = 0;
        hold = 12'd10; trig = 1; step(); trig = 0; ack = 1; step(); ack = 0;
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        check("holdoff.cycles_in_range", 32'(n >= 28 && n <= 30), 1);
        trig = 1; step(); trig = 0; ack = 1; step(); ack = 0;
        check("holdoff.second_trig_count", 32'(tc), 2);
        n = 0;
        while (busy && n < 40) begin step(); n++; end

        clr = 1; step(); clr = 0;
        hold = 12'd100; trig = 1; step(); trig = 0;
        repeat (8) step();
        trig = 1; step(); trig = 0; ack = 1; step(); ack = 0;
        repeat (7) step();
        trig = 1; step(); trig = 0;
        repeat (8) step();
        trig = 1; step(); trig = 0;
        check("lost.trig_count", 32'(tc), 1);
        check("lost.lost_count", 32'(lc), 3);
        check("lost.trig_out", 32'(tout), 0);
        hold = 12'd3;
        n = 0;
        while (busy && n < 400) begin step(); n++; end
        check("lost.back_to_idle", 32'(busy), 0);

        en = 0;
        repeat (4) begin trig = 1; step(); trig = 0; step(); end
        check("disarmed.trig_out", 32'(tout), 0);
        check("disarmed.trig_count", 32'(tc), 1);
        en = 1;

        clr = 1; step(); clr = 0; hold = 0;
        repeat (20) begin trig = 1; step(); trig = 0; ack = 1; step(); ack = 0; end
        check("sat.trig_count", 32'(tc), MAX);
        trig = 1; step(); trig = 0;
        repeat (20) begin step(); trig = 1; step(); trig = 0; end
        ack = 1; step(); ack = 0;
        check("sat.trig_count_stable", 32'(tc), MAX);
        check("sat.lost_count", 32'(lc), MAX);

        hold = 12'd100; trig = 1; step(); trig = 0; ack = 1; step(); ack = 0;
        repeat (150) step();
        check("midrst.busy_before", 32'(busy), 1);
        async_reset();
        hold = 0; trig = 1; step(); trig = 0;
        check("midrst.retrig_out", 32'(tout), 1);
        check("midrst.retrig_count", 32'(tc), 1);
        ack = 1; step(); ack = 0;

        for (int i = 0; i < 3000; i++) begin
            trig = ($urandom_range(0, 3) == 0);
            ack  = ($urandom_range(0, 4) == 0);
            en   = ($urandom_range(0, 9) != 0);
            clr  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) hold = HW'($urandom_range(0, 6));
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sb_trig_holdoff.md
Name: sb_trig_holdoff

Overview:
Downstream stage of the 40 MHz compatibility single-bin trigger. Converts the single-bin trigger pulse into a level request to the trigger master, held until acknowledged. After acknowledge, applies a programmable holdoff counted in 40 MHz ticks. Keeps saturating counts of accepted and lost (busy-time) triggers for rate monitoring.

Parameters:
HOLDOFF_WIDTH, 12, width of holdoff length in 40 MHz ticks.
COUNT_WIDTH, 24, width of accepted/lost trigger counters.

Ports:
CLK120  in  1  120 MHz system clock.
RESETN  in  1  asynchronous active-low reset.
ENABLE40  in  2  40 MHz phase; value 0 marks a 40 MHz tick.
ENABLE  in  1  arming; when 0, new trigger edges are ignored and not counted.
TRIG_IN  in  1  single-bin 40 MHz trigger; may stay high up to 3 CLK120 cycles.
HOLDOFF  in  HOLDOFF_WIDTH  holdoff length in 40 MHz ticks; 0 = none.
TRIG_ACK  in  1  acknowledge from trigger master.
COUNT_CLR  in  1  synchronous clear of both counters.
TRIG_OUT  out  1  trigger request level.
BUSY  out  1  high in PENDING or HOLDOFF.
TRIG_COUNT  out  COUNT_WIDTH  accepted triggers, saturating.
LOST_COUNT  out  COUNT_WIDTH  triggers dropped while busy, saturating.

Behaviour:
- Reset (RESETN=0, asynchronous): state IDLE; TRIG_OUT=0, BUSY=0, TRIG_COUNT=0, LOST_COUNT=0; holdoff counter=0; edge-detect register=0.
- Edge detect: PREV <= TRIG_IN every cycle. EDGE = TRIG_IN & ~PREV & ENABLE.
- A 3-cycle TRIG_IN pulse yields exactly one EDGE.
- State IDLE:
  - On EDGE, go to PENDING at the next edge. TRIG_OUT=1 and BUSY=1 from that edge, giving 1-cycle latency from the first cycle TRIG_IN is sampled high.
  - TRIG_COUNT increments on that same edge.
- State PENDING:
  - TRIG_OUT held at 1 until TRIG_ACK is sampled high in this state. TRIG_ACK in any other state is ignored.
  - On ACK with HOLDOFF==0: go to IDLE; TRIG_OUT=0 next cycle.
  - On ACK with HOLDOFF!=0: load the counter with HOLDOFF, go to HOLDOFF; TRIG_OUT=0.
  - No timeout.
- State HOLDOFF:
  - TRIG_OUT=0, BUSY=1.
  - On each cycle with ENABLE40==0, the counter decrements.
  - When the counter is 1 and a tick occurs, go to IDLE with counter=0. Busy time is therefore HOLDOFF ticks, ±2 CLK120 cycles for phase alignment.
- HOLDOFF is sampled only at ACK. Changes during holdoff have no effect.
- Lost triggers: EDGE in PENDING or HOLDOFF increments LOST_COUNT.
  - This includes an EDGE in the cycle the FSM leaves HOLDOFF or PENDING; the registered state is still busy.
- Counters:
  - Saturate at all-ones; no wrap.
  - COUNT_CLR has priority over a same-cycle increment: the counter goes to 0 and that event is not counted.
  - COUNT_CLR does not affect the FSM.
- Deasserting ENABLE mid-operation does not abort. PENDING still waits for ACK and holdoff completes; only new edges are suppressed.
- Reset mid-PENDING or mid-HOLDOFF drops TRIG_OUT immediately (asynchronous). No ACK is then expected.

Test Plan:
- Basic handshake: HOLDOFF=0, TRIG_IN high 3 cycles, ACK 5 cycles after TRIG_OUT rises. Expect TRIG_OUT high 1 cycle after TRIG_IN, held until ACK, low next cycle; TRIG_COUNT=1, LOST_COUNT=0.
- Holdoff timing: HOLDOFF=10, trigger then immediate ACK. Expect BUSY high for 10 ENABLE40==0 ticks (30±2 CLK120 cycles), then IDLE. A second trigger afterwards gives TRIG_COUNT=2.
- Lost triggers: HOLDOFF=100; three TRIG_IN pulses spaced 9 cycles after the first trigger, during PENDING and HOLDOFF. Expect TRIG_COUNT=1, LOST_COUNT=3, no extra TRIG_OUT.
- Arming and clear: ENABLE=0 with 4 pulses gives counters unchanged and TRIG_OUT=0. COUNT_CLR coincident with an accepted edge gives TRIG_COUNT=0 while TRIG_OUT still asserts.
- Saturation: preload via 2^COUNT_WIDTH-1 events (or COUNT_WIDTH=4 build, 20 triggers). Expect TRIG_COUNT=15, stable.
- Reset mid-operation: assert RESETN=0 during HOLDOFF with counter=50. Expect TRIG_OUT=0, BUSY=0, counters 0 asynchronously; after release, the next trigger is accepted normally.
